// File: rtl/hyst_thresh_stream_if.sv
// Pixel stream bundle for hyst_thresh_stream.
// Carries the raster input handshake and the thresholded output stream.
interface hyst_thresh_stream_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sof;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sof;
    logic                  out_eof;

    modport master (
        output in_valid, in_sof, in_data,
        input  in_ready, out_valid, out_data, out_sof, out_eof
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output in_ready, out_valid, out_data, out_sof, out_eof
    );
endinterface

// File: rtl/hyst_thresh_stream.sv
// Streaming 3x3 hysteresis threshold stage with internal line buffers.
// Optional THRESH_STATS_EN adds per-frame strong/promoted/edge counters.
module hyst_thresh_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int WIDTH      = 640,
    parameter int DEPTH      = 504
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hyst_thresh_stream_if.slave   strm,
    input  logic [DATA_WIDTH-1:0] th_hi,
    input  logic [DATA_WIDTH-1:0] th_lo,
    input  logic                  bin_mode,
    input  logic                  clr_err,
    output logic                  busy,
    output logic                  ovf_err,
    output logic                  sof_err
`ifdef THRESH_STATS_EN
    ,
    output logic [31:0]           stat_strong,
    output logic [31:0]           stat_promoted,
    output logic [31:0]           stat_edge,
    output logic                  stat_valid
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(DEPTH);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    typedef logic [DATA_WIDTH-1:0] pix_t;

    state_t        state;
    logic [CW-1:0] in_col, out_col, wr_col;
    logic [RW-1:0] in_row, out_row;
    pix_t          hi_q, lo_q;
    logic          bin_q;
    pix_t          lb1 [WIDTH];
    pix_t          lb2 [WIDTH];
    pix_t          wa [3];
    pix_t          wb [3];
    pix_t          nc [3];
    logic          acc, start, emit, border, out_last;
    logic          nb_strong, c_strong, c_weak, promoted, is_edge;

    assign strm.in_ready = (state != FLUSH);
    assign busy          = (state != IDLE);
    assign acc           = strm.in_valid && strm.in_ready;
    assign start         = acc && strm.in_sof;
    assign emit          = (state == FLUSH) || (state == RUN && acc && !start);
    assign wr_col        = start ? '0 : in_col;

    // Window columns: wa oldest, wb middle, nc arriving this cycle
    assign nc[0] = lb2[wr_col];
    assign nc[1] = lb1[wr_col];
    assign nc[2] = strm.in_data;

    assign border   = (out_row == '0) || (out_row == ROW_LAST) ||
                      (out_col == '0) || (out_col == COL_LAST);
    assign out_last = (out_row == ROW_LAST) && (out_col == COL_LAST);

    assign nb_strong = (wa[0] > hi_q) || (wb[0] > hi_q) || (nc[0] > hi_q) ||
                       (wa[1] > hi_q) || (nc[1] > hi_q) ||
                       (wa[2] > hi_q) || (wb[2] > hi_q) || (nc[2] > hi_q);
    assign c_strong  = !border && (wb[1] > hi_q);
    assign c_weak    = !border && (wb[1] >= lo_q) && (wb[1] <= hi_q);
    assign promoted  = c_weak && nb_strong;
    assign is_edge   = c_strong || promoted;

    always_ff @(posedge clk) begin
        if (acc) begin
            lb2[wr_col] <= lb1[wr_col];
            lb1[wr_col] <= strm.in_data;
            wa <= wb;
            wb <= nc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
            sof_err <= 1'b0;
        end else begin
            if (strm.in_valid && !strm.in_ready) ovf_err <= 1'b1;
            else if (clr_err)                    ovf_err <= 1'b0;
            if (start && (state == FILL || state == RUN)) sof_err <= 1'b1;
            else if (clr_err)                             sof_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            in_col         <= '0;
            in_row         <= '0;
            out_col        <= '0;
            out_row        <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            bin_q          <= 1'b0;
            strm.out_valid <= 1'b0;
            strm.out_data  <= '0;
            strm.out_sof   <= 1'b0;
            strm.out_eof   <= 1'b0;
        end else begin
            strm.out_valid <= emit;
            strm.out_sof   <= emit && (out_row == '0) && (out_col == '0);
            strm.out_eof   <= emit && out_last;
            strm.out_data  <= (emit && is_edge) ? (bin_q ? '1 : wb[1]) : '0;
            if (emit) begin
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end
            if (acc) begin
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
                end else begin
                    in_col <= in_col + 1'b1;
                end
            end
            // A sof pixel always opens a fresh frame, aborting any current one
            if (start) begin
                state   <= FILL;
                hi_q    <= th_hi;
                lo_q    <= th_lo;
                bin_q   <= bin_mode;
                in_col  <= CW'(1);
                in_row  <= '0;
                out_col <= '0;
                out_row <= '0;
            end else begin
                unique case (state)
                    FILL:    if (acc && in_col == '0) state <= RUN;
                    RUN:     if (acc && in_row == ROW_LAST && in_col == COL_LAST)
                                 state <= FLUSH;
                    FLUSH:   if (out_last) state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

`ifdef THRESH_STATS_EN
    logic [31:0] cnt_strong, cnt_prom, cnt_edge;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_strong    <= '0;
            cnt_prom      <= '0;
            cnt_edge      <= '0;
            stat_strong   <= '0;
            stat_promoted <= '0;
            stat_edge     <= '0;
            stat_valid    <= 1'b0;
        end else begin
            stat_valid <= strm.out_eof;
            if (strm.out_eof) begin
                stat_strong   <= cnt_strong;
                stat_promoted <= cnt_prom;
                stat_edge     <= cnt_edge;
            end
            if (start) begin
                cnt_strong <= '0;
                cnt_prom   <= '0;
                cnt_edge   <= '0;
            end else if (emit) begin
                cnt_strong <= cnt_strong + 32'(c_strong);
                cnt_prom   <= cnt_prom + 32'(promoted);
                cnt_edge   <= cnt_edge + 32'(is_edge);
            end
        end
    end
`endif
endmodule

// File: tb/tb_hyst_thresh_stream.sv
// Bench for hyst_thresh_stream on 8x6 frames.
// Whole-frame reference results come straight from the 3x3 hysteresis rule.
module tb_hyst_thresh_stream;
    localparam int W = 8;
    localparam int D = 6;
    localparam int N = W * D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] th_hi = '0;
    logic [15:0] th_lo = '0;
    logic        bin_mode = 1'b0;
    logic        clr_err = 1'b0;
    logic        busy, ovf_err, sof_err;
`ifdef THRESH_STATS_EN
    logic [31:0] stat_strong, stat_promoted, stat_edge;
    logic        stat_valid;
    logic        st_seen = 1'b0;
    logic [31:0] st_s, st_p, st_e;
`endif

    hyst_thresh_stream_if #(.DATA_WIDTH(16)) bus ();

    hyst_thresh_stream #(
        .DATA_WIDTH(16),
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .strm(bus.slave),
        .th_hi(th_hi),
        .th_lo(th_lo),
        .bin_mode(bin_mode),
        .clr_err(clr_err),
        .busy(busy),
        .ovf_err(ovf_err),
        .sof_err(sof_err)
`ifdef THRESH_STATS_EN
        ,
        .stat_strong(stat_strong),
        .stat_promoted(stat_promoted),
        .stat_edge(stat_edge),
        .stat_valid(stat_valid)
`endif
    );

    always #5 clk = ~clk;

    int          img [D][W];
    int          expf [N];
    logic [17:0] exp_q [$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          out_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    endtask

    always @(negedge clk) begin : cmp
        logic [17:0] e;
        if (bus.out_valid === 1'b1) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_out: got data %0h sof %b eof %b, expected no output",
                         bus.out_data, bus.out_sof, bus.out_eof);
            end else begin
                e = exp_q.pop_front();
                chk("stream", {bus.out_eof, bus.out_sof, bus.out_data}, e);
            end
        end
    end

`ifdef THRESH_STATS_EN
    always @(negedge clk) begin
        if (stat_valid === 1'b1) begin
            st_seen = 1'b1;
            st_s = stat_strong;
            st_p = stat_promoted;
            st_e = stat_edge;
        end
    end
`endif

    function automatic void fill(input int v);
        for (int r = 0; r < D; r++)
            for (int c = 0; c < W; c++) img[r][c] = v;
    endfunction

    function automatic void model(input int hi, input int lo, input bit bin);
        int  p, v;
        bit  ns;
        for (int r = 0; r < D; r++) begin
            for (int c = 0; c < W; c++) begin
                v = 0;
                if (r > 0 && r < D - 1 && c > 0 && c < W - 1) begin
                    ns = 0;
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++)
                            if ((dr != 0 || dc != 0) && img[r+dr][c+dc] > hi) ns = 1;
                    p = img[r][c];
                    if (p > hi || (p >= lo && p <= hi && ns)) v = bin ? 65535 : p;
                end
                expf[r*W+c] = v;
            end
        end
    endfunction

    function automatic void push_exp(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == N - 1), (i == 0), 16'(expf[i])});
    endfunction

    task automatic send(input int d, input bit sof, input bit gap);
        int g;
        @(negedge clk);
        if (gap) begin
            g = 0;
            while ($urandom_range(0, 1) == 0 && g < 8) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
                g++;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_data  = 16'(d);
        g = 0;
        while (bus.in_ready !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g == 100) begin
            n_chk++;
            $display("FAIL send_ready: in_ready %b, expected 1", bus.in_ready);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic run_frame(input int hi, input int lo, input bit bin,
                             input int npix, input bit gap, input bit first_chk);
        th_hi    = 16'(hi);
        th_lo    = 16'(lo);
        bin_mode = bin;
        for (int i = 0; i < npix; i++) begin
            send(img[i/W][i%W], (i == 0), gap);
            if (first_chk && i == 9)  chk("no_out_before_10th", bus.out_valid, 1'b0);
            if (first_chk && i == 10) chk("first_out_after_10th", bus.out_valid, 1'b1);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else begin
            $display("FAIL drain: %0d outputs missing, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_ovf_err", ovf_err, 1'b0);
        chk("rst_sof_err", sof_err, 1'b0);
        rst_n = 1'b1;

        // Uniform strong frame
        fill(600);
        model(500, 400, 0);
        chk("model_t1_corner", expf[0], 0);
        chk("model_t1_interior", expf[1*W+1], 600);
        chk("model_t1_lastcol", expf[2*W+7], 0);
        push_exp(N);
        out_cnt = 0;
        run_frame(500, 400, 0, N, 0, 1);
        idle();
        drain();
        chk("t1_count", out_cnt, 48);

        // Single strong pixel among weak ones
        fill(450);
        img[2][3] = 600;
        model(500, 400, 0);
        chk("model_t2_centre", expf[2*W+3], 600);
        chk("model_t2_nbr", expf[1*W+2], 450);
        chk("model_t2_far", expf[3*W+5], 0);
        chk("model_t2_below", expf[4*W+4], 0);
        push_exp(N);
`ifdef THRESH_STATS_EN
        st_seen = 1'b0;
`endif
        run_frame(500, 400, 0, N, 0, 0);
        idle();
        drain();
`ifdef THRESH_STATS_EN
        chk("stat_valid_seen", st_seen, 1'b1);
        chk("stat_strong", st_s, 1);
        chk("stat_promoted", st_p, 8);
        chk("stat_edge", st_e, 9);
`endif
        model(500, 400, 1);
        chk("model_t2_bin", expf[3*W+4], 65535);
        push_exp(N);
        run_frame(500, 400, 1, N, 0, 0);
        idle();
        drain();

        // Class boundaries, then th_lo above th_hi
        fill(0);
        img[1][1] = 450;
        img[1][5] = 399;
        img[1][6] = 600;
        img[2][6] = 500;
        img[3][2] = 400;
        img[4][3] = 501;
        model(500, 400, 0);
        chk("model_t3_lonely_weak", expf[1*W+1], 0);
        chk("model_t3_below_lo", expf[1*W+5], 0);
        chk("model_t3_lo_promoted", expf[3*W+2], 400);
        chk("model_t3_hi_promoted", expf[2*W+6], 500);
        push_exp(N);
        run_frame(500, 400, 0, N, 0, 0);
        idle();
        drain();
        model(500, 700, 0);
        chk("model_t3_single_lo", expf[3*W+2], 0);
        chk("model_t3_single_eq", expf[2*W+6], 0);
        chk("model_t3_single_pass", expf[4*W+3], 501);
        push_exp(N);
        run_frame(500, 700, 0, N, 0, 0);
        idle();
        drain();

        // Random input gaps
        fill(600);
        model(500, 400, 0);
        push_exp(N);
        out_cnt = 0;
        run_frame(500, 400, 0, N, 1, 0);
        idle();
        drain();
        chk("t4_count", out_cnt, 48);

        // Abort by early sof, then overflow during flush
        push_exp(20 - (W + 1));
        push_exp(N);
        run_frame(500, 400, 0, 20, 0, 0);
        run_frame(500, 400, 0, N, 0, 0);
        chk("t5_sof_err", sof_err, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t5_ovf_err", ovf_err, 1'b1);
        drain();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t5_clr_ovf", ovf_err, 1'b0);
        chk("t5_clr_sof", sof_err, 1'b0);

        // Reset pulse mid-frame
        fill(450);
        img[2][3] = 600;
        model(500, 400, 0);
        push_exp(30 - (W + 1));
        run_frame(500, 400, 0, 30, 0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_out_valid", bus.out_valid, 1'b0);
        drain();
        fill(600);
        model(500, 400, 0);
        push_exp(N);
        run_frame(500, 400, 0, N, 0, 0);
        idle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
